// File: rtl/cpu_phase_controller_if.sv
// Control bundle between the phase sequencer and the CPU datapath/memory.
// The master side is the sequencer; the slave side is the datapath it steers.
interface cpu_phase_controller_if;
  logic       en;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       sel;
  logic       rd;
  logic       ld_ir;
  logic       ld_ac;
  logic       ld_pc;
  logic [1:0] inc_pc;
  logic       data_e;
  logic       wr;
  logic       halt;
  logic [2:0] phase;
  logic       instr_done;

  modport master (
    input  en, opcode, zero, mem_ready,
    output sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, data_e, wr, halt, phase, instr_done
  );

  modport slave (
    output en, opcode, zero, mem_ready,
    input  sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, data_e, wr, halt, phase, instr_done
  );
endinterface

// File: rtl/cpu_phase_controller.sv
// Eight-phase instruction sequencer for the 5-bit-address RISC CPU.
// Outputs are decoded combinationally from phase, halted flag, opcode, zero and mem_ready.
module cpu_phase_controller (
  input  logic                          clk,
  input  logic                          rst,
  cpu_phase_controller_if.master        bus
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OPC_HLT = 3'd0;
  localparam logic [2:0] OPC_SKZ = 3'd1;
  localparam logic [2:0] OPC_ADD = 3'd2;
  localparam logic [2:0] OPC_AND = 3'd3;
  localparam logic [2:0] OPC_XOR = 3'd4;
  localparam logic [2:0] OPC_LDA = 3'd5;
  localparam logic [2:0] OPC_STO = 3'd6;
  localparam logic [2:0] OPC_JMP = 3'd7;

  phase_e     phase_q, phase_d;
  logic       halted_q, halted_d;

  logic       is_alu, is_sto, is_jmp, is_hlt, is_skz;
  logic       advance;
  logic       sel, rd, ld_ir, ld_ac, ld_pc, data_e, wr, halt, instr_done;
  logic [1:0] inc_pc;

  always_comb begin
    is_hlt = (bus.opcode == OPC_HLT);
    is_skz = (bus.opcode == OPC_SKZ);
    is_sto = (bus.opcode == OPC_STO);
    is_jmp = (bus.opcode == OPC_JMP);
    is_alu = (bus.opcode == OPC_ADD) || (bus.opcode == OPC_AND) ||
             (bus.opcode == OPC_XOR) || (bus.opcode == OPC_LDA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Only the wait-capable phases (INST_ADDR, INST_FETCH, OP_FETCH, STORE) and a
  // HLT in OP_ADDR can hold; once halted nothing moves until reset.
  always_comb begin
    advance = 1'b1;
    case (phase_q)
      INST_ADDR:  advance = bus.en;
      INST_FETCH: advance = bus.mem_ready;
      OP_ADDR:    advance = !is_hlt;
      OP_FETCH:   advance = !is_alu || bus.mem_ready;
      STORE:      advance = !is_sto || bus.mem_ready;
      default:    advance = 1'b1;
    endcase
    if (halted_q) advance = 1'b0;

    phase_d  = advance ? phase_e'(phase_q + 3'd1) : phase_q;
    halted_d = halted_q || (phase_q == OP_ADDR && is_hlt);
  end

  always_comb begin
    sel        = 1'b0;
    rd         = 1'b0;
    ld_ir      = 1'b0;
    ld_ac      = 1'b0;
    ld_pc      = 1'b0;
    inc_pc     = 2'd0;
    data_e     = 1'b0;
    wr         = 1'b0;
    halt       = 1'b0;
    instr_done = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR: sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          if (is_hlt) halt = 1'b1;
          else        inc_pc = (is_skz && bus.zero) ? 2'd2 : 2'd1;
        end
        OP_FETCH: rd = is_alu;
        ALU_OP: begin
          rd     = is_alu;
          data_e = is_sto;
        end
        STORE: begin
          rd         = is_alu;
          ld_ac      = is_alu;
          ld_pc      = is_jmp;
          data_e     = is_sto;
          wr         = is_sto;
          instr_done = advance;
        end
        default: ;
      endcase
    end
  end

  assign bus.sel        = sel;
  assign bus.rd         = rd;
  assign bus.ld_ir      = ld_ir;
  assign bus.ld_ac      = ld_ac;
  assign bus.ld_pc      = ld_pc;
  assign bus.inc_pc     = inc_pc;
  assign bus.data_e     = data_e;
  assign bus.wr         = wr;
  assign bus.halt       = halt;
  assign bus.phase      = phase_q;
  assign bus.instr_done = instr_done;

endmodule

// File: doc/cpu_phase_controller.md
Name: cpu_phase_controller

Overview:
- Eight-phase instruction sequencer for the 5-bit-address RISC CPU.
- Drives the program counter (load, 2-bit inc_pc), instruction register, accumulator and memory strobes from the current phase, the IR opcode and the accumulator zero flag.
- Stretches memory phases with a mem_ready handshake.
- Freezes on HLT until reset.

Parameters:
- NONE, -, no parameters; opcode encoding is fixed: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  run enable, sampled only at instruction boundary
- opcode  input  3  IR opcode field, stable from OP_ADDR through STORE
- zero  input  1  accumulator==0 flag, registered upstream
- mem_ready  input  1  memory completion handshake
- sel  output  1  address mux: 1=PC, 0=IR operand
- rd  output  1  memory read strobe
- ld_ir  output  1  instruction register load
- ld_ac  output  1  accumulator load
- ld_pc  output  1  PC load (drives PC load; PC gives load priority over increment)
- inc_pc  output  2  PC increment: 0 none, 1 +1, 2 +2 (skip)
- data_e  output  1  accumulator-to-bus drive enable
- wr  output  1  memory write strobe
- halt  output  1  CPU halted
- phase  output  3  current phase, debug
- instr_done  output  1  one-cycle pulse on instruction retire

Behaviour:
- Phase register, 3-bit encoding:
  - INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
  - Separate 1-bit halted flag.
- Timing: all outputs combinational from phase/halted/opcode/zero/mem_ready. The PC/IR/AC act on the rising edge that ends the phase.
- ALUOP = ADD|AND|XOR|LDA.
- Outputs per phase (unlisted outputs = 0):
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD: sel, rd, ld_ir.
  - IDLE: sel, rd, ld_ir.
  - OP_ADDR, opcode HLT: halt=1, inc_pc=0.
  - OP_ADDR, other opcodes: inc_pc=2 if (opcode==SKZ && zero), else 1.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP, data_e=STO.
  - STORE: rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, data_e=STO, wr=STO.
- Transitions:
  - INST_ADDR advances only when en=1; en=0 holds INST_ADDR with sel=1.
  - INST_FETCH waits for mem_ready=1.
  - OP_FETCH waits for mem_ready=1 only if ALUOP; otherwise advances next cycle.
  - STORE waits for mem_ready=1 only if STO; otherwise advances.
  - All other phases advance unconditionally each cycle.
  - STORE wraps to INST_ADDR.
- Wait states: all outputs for the phase are held constant. inc_pc and ld_pc are never asserted in a wait-capable phase, so the PC updates exactly once per instruction.
- Skip: SKZ with zero=1 produces a single inc_pc=2 cycle, never two +1 cycles.
- JMP: the PC gets +1 at OP_ADDR, then the load at STORE overrides it. Final PC = operand.
- HLT: the edge ending OP_ADDR sets halted.
  - Halted: phase frozen at 4, halt=1, all other outputs 0, instr_done never pulses.
  - en and mem_ready are ignored while halted. Only rst exits.
- en deassertion mid-instruction has no effect until the next INST_ADDR.
- instr_done = (phase==STORE && advancing), one cycle wide per instruction.
- Reset (async, any phase incl. wait or halted): phase=INST_ADDR, halted=0. During and after reset: sel=1, all other outputs 0, phase=0.

Test Plan:
- Reset then en=1, mem_ready=1, opcode=ADD: phase steps 0..7 in 8 cycles. inc_pc=1 only at phase 4; ld_ac=1 only at phase 7; instr_done pulses at cycle 8.
- SKZ with zero=1: inc_pc=2 for exactly one cycle at phase 4, PC 3->5. With zero=0: inc_pc=1, PC 3->4.
- JMP operand 0x1A from PC 2: inc_pc=1 at phase 4, ld_pc=1 at phase 7, PC ends 0x1A. wr=0, rd=0 in phases 5-7.
- STO with mem_ready low 3 cycles in STORE: wr and data_e held 4 cycles, phase stays 7, instr_done pulses once when mem_ready rises. Also mem_ready low 2 cycles in INST_FETCH: phase holds at 1.
- HLT: halt=1 at phase 4 and then permanently; 20 further cycles with en=1 show phase=4 and no strobes. rst pulse returns phase=0, halt=0, sel=1.
- en=0 at reset: phase held 0 for 5 cycles. en dropped during phase 5 of an ADD: instruction completes, then holds at phase 0. rst asserted during phase 6: immediate phase=0, ld_ac never asserted.
